// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the instruction fetch
//               controller, the PC block and the benches.
//               - fetch_state_t : fetch controller state encoding
//               - RESET_VECTOR  : first address fetched after reset
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  // First instruction address; the PC block resets to this value.
  localparam logic [31:0] RESET_VECTOR = 32'h0040_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch
// Description : Fetch controller between the PC block and decode. Reads the
//               PC, fetches the word over a req/ack memory port, presents it
//               to decode with valid/ready, and turns execute redirects into
//               PC loads while discarding any fetch in flight.
// Ports       :
//   clk                 in   system clock, rising edge
//   rst                 in   asynchronous active-low reset
//   pcAddress           in   current PC
//   count               out  pulse: advance PC by 4
//   shouldUseNewPC      out  pulse: load newPC into the PC
//   newPC               out  PC load value (0 when not loading)
//   redirect            in   branch/jump taken from execute
//   redirectTarget      in   redirect destination
//   memReq              out  instruction-memory read request
//   memAddress          out  read address
//   memAck              in   read-data-valid pulse
//   memData             in   read data, valid with memAck
//   instruction         out  fetched word to decode
//   instructionAddress  out  address of instruction
//   instructionValid    out  output register holds a live word
//   decodeReady         in   decode accepts the word this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] pcAddress,
  output logic                  count,
  output logic                  shouldUseNewPC,
  output logic [ADDR_WIDTH-1:0] newPC,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirectTarget,
  output logic                  memReq,
  output logic [ADDR_WIDTH-1:0] memAddress,
  input  logic                  memAck,
  input  logic [DATA_WIDTH-1:0] memData,
  output logic [DATA_WIDTH-1:0] instruction,
  output logic [ADDR_WIDTH-1:0] instructionAddress,
  output logic                  instructionValid,
  input  logic                  decodeReady
);

  fetch_state_t          state_q;
  logic [ADDR_WIDTH-1:0] drain_addr_q;
  logic [DATA_WIDTH-1:0] instr_q;
  logic [ADDR_WIDTH-1:0] instr_addr_q;
  logic                  instr_valid_q;

  assign instruction        = instr_q;
  assign instructionAddress = instr_addr_q;
  assign instructionValid   = instr_valid_q;

  // PC control and memory request are decoded from state and inputs so the
  // PC updates on the same edge that the controller changes state.
  always_comb begin
    count          = 1'b0;
    shouldUseNewPC = 1'b0;
    newPC          = '0;
    memReq         = 1'b0;
    memAddress     = '0;

    if (redirect) begin
      shouldUseNewPC = 1'b1;
      newPC          = redirectTarget;
    end

    case (state_q)
      FETCH: begin
        memReq     = 1'b1;
        memAddress = pcAddress;
        // A redirect wins over the advance; both PC controls never coexist.
        count      = memAck & ~redirect;
      end
      DRAIN: begin
        // Keep presenting the stale address until its ack retires it.
        memReq     = 1'b1;
        memAddress = drain_addr_q;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      drain_addr_q  <= '0;
      instr_q       <= '0;
      instr_addr_q  <= '0;
      instr_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          instr_valid_q <= 1'b0;
          state_q       <= FETCH;
        end

        FETCH: begin
          if (redirect) begin
            instr_valid_q <= 1'b0;
            if (memAck) begin
              // Request already retired; its data is simply dropped.
              state_q <= FETCH;
            end else begin
              drain_addr_q <= pcAddress;
              state_q      <= DRAIN;
            end
          end else if (memAck) begin
            instr_q       <= memData;
            instr_addr_q  <= pcAddress;
            instr_valid_q <= 1'b1;
            state_q       <= HOLD;
          end
        end

        HOLD: begin
          if (redirect || decodeReady) begin
            instr_valid_q <= 1'b0;
            state_q       <= FETCH;
          end
        end

        DRAIN: begin
          if (redirect) begin
            instr_valid_q <= 1'b0;
          end
          // The outstanding stale request completes here even if another
          // redirect coincides; waiting longer would deadlock the port.
          if (memAck) begin
            state_q <= FETCH;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule : instruction_fetch
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_fetch
// Description : Directed self-checking bench for instruction_fetch, with a
//               small PC model driven by the DUT's PC controls.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch;
  import fetch_pkg::*;

  localparam int DW = 32;
  localparam int AW = 32;

  logic          clk;
  logic          rst;
  logic [AW-1:0] pcAddress;
  logic          count;
  logic          shouldUseNewPC;
  logic [AW-1:0] newPC;
  logic          redirect;
  logic [AW-1:0] redirectTarget;
  logic          memReq;
  logic [AW-1:0] memAddress;
  logic          memAck;
  logic [DW-1:0] memData;
  logic [DW-1:0] instruction;
  logic [AW-1:0] instructionAddress;
  logic          instructionValid;
  logic          decodeReady;

  int checks = 0;
  int errors = 0;

  instruction_fetch #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .pcAddress         (pcAddress),
    .count             (count),
    .shouldUseNewPC    (shouldUseNewPC),
    .newPC             (newPC),
    .redirect          (redirect),
    .redirectTarget    (redirectTarget),
    .memReq            (memReq),
    .memAddress        (memAddress),
    .memAck            (memAck),
    .memData           (memData),
    .instruction       (instruction),
    .instructionAddress(instructionAddress),
    .instructionValid  (instructionValid),
    .decodeReady       (decodeReady)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PC block model: load has priority over advance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                pcAddress <= RESET_VECTOR;
    else if (shouldUseNewPC) pcAddress <= newPC;
    else if (count)          pcAddress <= pcAddress + 32'd4;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are then changed 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst            = 1'b0;
    redirect       = 1'b0;
    redirectTarget = '0;
    memAck         = 1'b0;
    memData        = '0;
    decodeReady    = 1'b1;

    // ---------------- reset state ----------------
    cyc(); cyc();
    #1;
    chk("rst_memReq",   {31'd0, memReq},           32'd0);
    chk("rst_count",    {31'd0, count},            32'd0);
    chk("rst_useNew",   {31'd0, shouldUseNewPC},   32'd0);
    chk("rst_valid",    {31'd0, instructionValid}, 32'd0);
    chk("rst_instr",    instruction,               32'd0);
    chk("rst_iaddr",    instructionAddress,        32'd0);
    chk("rst_newPC",    newPC,                     32'd0);
    chk("rst_pc",       pcAddress,                 32'h0040_0000);

    // ---------------- zero-wait sequential fetch + decode stall ----------------
    cyc(); rst = 1'b1;                       // IDLE
    #1; chk("idle_memReq", {31'd0, memReq}, 32'd0);
    cyc();                                   // FETCH @ 0x00400000
    chk("f0_memReq", {31'd0, memReq}, 32'd1);
    chk("f0_addr",   memAddress,      32'h0040_0000);
    memAck = 1'b1; memData = 32'h2008_0001;
    #1; chk("f0_count", {31'd0, count}, 32'd1);
    cyc(); memAck = 1'b0; decodeReady = 1'b0; // HOLD with word 0
    #1;
    chk("w0_valid", {31'd0, instructionValid}, 32'd1);
    chk("w0_instr", instruction,               32'h2008_0001);
    chk("w0_iaddr", instructionAddress,        32'h0040_0000);
    chk("w0_pc",    pcAddress,                 32'h0040_0004);
    for (int i = 0; i < 3; i++) begin
      chk("stall_valid",  {31'd0, instructionValid}, 32'd1);
      chk("stall_instr",  instruction,               32'h2008_0001);
      chk("stall_memReq", {31'd0, memReq},           32'd0);
      chk("stall_count",  {31'd0, count},            32'd0);
      cyc();
    end
    decodeReady = 1'b1;
    #1; chk("ready_valid", {31'd0, instructionValid}, 32'd1);
    cyc();                                   // FETCH @ 0x00400004
    chk("f1_valid",  {31'd0, instructionValid}, 32'd0);
    chk("f1_memReq", {31'd0, memReq},           32'd1);
    chk("f1_addr",   memAddress,                32'h0040_0004);
    memAck = 1'b1; memData = 32'h2009_0002;
    #1; chk("f1_count", {31'd0, count}, 32'd1);
    cyc(); memAck = 1'b0;
    #1;
    chk("w1_instr", instruction,        32'h2009_0002);
    chk("w1_iaddr", instructionAddress, 32'h0040_0004);
    chk("w1_pc",    pcAddress,          32'h0040_0008);
    chk("w1_count", {31'd0, count},     32'd0);

    // ---------------- wait states (restart from reset) ----------------
    rst = 1'b0; cyc(); rst = 1'b1;           // IDLE
    cyc();                                   // FETCH @ 0x00400000
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("ws_memReq", {31'd0, memReq}, 32'd1);
      chk("ws_addr",   memAddress,      32'h0040_0000);
      chk("ws_count",  {31'd0, count},  32'd0);
      cyc();
    end
    memAck = 1'b1; memData = 32'h1111_1111;
    #1; chk("ws_ack_count", {31'd0, count}, 32'd1);
    cyc(); memAck = 1'b0;                    // HOLD, decodeReady=1
    #1;
    chk("ws_instr", instruction,        32'h1111_1111);
    chk("ws_pc",    pcAddress,          32'h0040_0004);
    cyc();                                   // FETCH @ 0x00400004

    // ---------------- redirect during wait ----------------
    #1; chk("rd_wait1_addr", memAddress, 32'h0040_0004);
    cyc();                                   // second wait cycle
    redirect = 1'b1; redirectTarget = 32'hABCD_ABCD;
    #1;
    chk("rd_useNew", {31'd0, shouldUseNewPC}, 32'd1);
    chk("rd_newPC",  newPC,                   32'hABCD_ABCD);
    chk("rd_count",  {31'd0, count},          32'd0);
    cyc(); redirect = 1'b0; redirectTarget = '0;   // DRAIN
    #1;
    chk("dr_useNew", {31'd0, shouldUseNewPC},   32'd0);
    chk("dr_newPC",  newPC,                     32'd0);
    chk("dr_memReq", {31'd0, memReq},           32'd1);
    chk("dr_addr",   memAddress,                32'h0040_0004);
    chk("dr_pc",     pcAddress,                 32'hABCD_ABCD);
    cyc();
    #1; chk("dr2_addr", memAddress, 32'h0040_0004);
    memAck = 1'b1; memData = 32'hDEAD_BEEF;
    #1; chk("dr_ack_count", {31'd0, count}, 32'd0);
    cyc(); memAck = 1'b0;                    // FETCH @ target
    #1;
    chk("dr_valid",  {31'd0, instructionValid}, 32'd0);
    chk("tgt_req",   {31'd0, memReq},           32'd1);
    chk("tgt_addr",  memAddress,                32'hABCD_ABCD);

    // ---------------- redirect coincident with memAck ----------------
    memAck = 1'b1; memData = 32'hCAFE_F00D;
    redirect = 1'b1; redirectTarget = 32'h0000_1000;
    #1;
    chk("co_count",  {31'd0, count},          32'd0);
    chk("co_useNew", {31'd0, shouldUseNewPC}, 32'd1);
    cyc(); memAck = 1'b0; redirect = 1'b0; redirectTarget = '0;
    #1;
    chk("co_valid", {31'd0, instructionValid}, 32'd0);
    chk("co_instr", instruction,               32'h1111_1111);
    chk("co_addr",  memAddress,                32'h0000_1000);
    chk("co_pc",    pcAddress,                 32'h0000_1000);

    // ---------------- reset mid-wait ----------------
    cyc(); #2;                               // still waiting in FETCH
    rst = 1'b0;
    #1;
    chk("mr_memReq", {31'd0, memReq},           32'd0);
    chk("mr_addr",   memAddress,                32'd0);
    chk("mr_valid",  {31'd0, instructionValid}, 32'd0);
    chk("mr_instr",  instruction,               32'd0);
    chk("mr_iaddr",  instructionAddress,        32'd0);
    chk("mr_count",  {31'd0, count},            32'd0);
    cyc(); rst = 1'b1;                       // IDLE, late ack arrives
    memAck = 1'b1; memData = 32'hBADB_AD00;
    #1;
    chk("late_count",  {31'd0, count},  32'd0);
    chk("late_memReq", {31'd0, memReq}, 32'd0);
    cyc(); memAck = 1'b0;                    // FETCH @ reset vector
    #1;
    chk("late_valid", {31'd0, instructionValid}, 32'd0);
    chk("rs_addr",    memAddress,                32'h0040_0000);
    memAck = 1'b1; memData = 32'h2222_2222;
    cyc(); memAck = 1'b0;
    #1;
    chk("rs_instr", instruction,        32'h2222_2222);
    chk("rs_iaddr", instructionAddress, 32'h0040_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_instruction_fetch
`default_nettype wire
